// File: rtl/vga_native_regs.sv
// vga_native_regs
//   Native-bus register block for a simple VGA framebuffer writer. The CPU
//   configures the block and pushes pixels into a small FIFO. The FIFO drains
//   into the framebuffer at an auto-incrementing pixel address.
//
//   Register map (word addresses):
//     0 CTRL      RW  [0] enable, [1] irq_en
//     1 STATUS    R/W1C [0] empty [1] full [2] overflow [3] vsync_pend [15:8] level
//     2 FB_ADDR   RW  [FB_ADDR_W-1:0]
//     3 FB_DATA   WO  push data2native[PIXEL_W-1:0]; reads 0
//     4 FRAME_CNT RO  vsync rising-edge count
//     5-15        read 0, writes ignored
//
//   Ports:
//     clk_i, arst_ni                  clock, async active-low reset
//     addr_write/write_en/data2native write channel (one-cycle strobe)
//     addr_read/read_en_sync          read channel (one-cycle strobe)
//     data2axil                       registered read data, held between reads
//     vsync_i                         vsync level, synchronous to clk_i
//     enable_o, irq_o                 CTRL[0], registered interrupt
//     fb_valid_o/fb_ready_i           pixel write handshake
//     fb_addr_o/fb_data_o             pixel address / FIFO head
//
//   Build option: define VGA_NATIVE_REGS_FRAME_CNT_EN to build the frame
//   counter. Without it, FRAME_CNT reads 0 and no counter is built.
module vga_native_regs #(
  parameter int FIFO_DEPTH = 8,
  parameter int PIXEL_W    = 12,
  parameter int FB_ADDR_W  = 19,
  parameter int FB_SIZE    = 307200
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic [3:0]           addr_write,
  input  logic                 write_en,
  input  logic [31:0]          data2native,
  input  logic [3:0]           addr_read,
  input  logic                 read_en_sync,
  output logic [31:0]          data2axil,
  input  logic                 vsync_i,
  output logic                 enable_o,
  output logic                 irq_o,
  output logic                 fb_valid_o,
  input  logic                 fb_ready_i,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic [PIXEL_W-1:0]   fb_data_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // State
  logic [1:0]           ctrl_q,  ctrl_d;
  logic                 ovf_q,   ovf_d;
  logic                 vpend_q, vpend_d;
  logic [FB_ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q;
  logic                 vsync_q;
  logic [AW:0]          wptr_q, rptr_q;   // extra MSB tells full from empty
  logic [PIXEL_W-1:0]   mem_q [FIFO_DEPTH];

  // Decode
  logic        wr_ctrl, wr_stat, wr_addr, push, pop, push_ok;
  logic        empty, full, vs_rise;
  logic [AW:0] level;
  logic [31:0] frame_cnt, rd_mux;

  assign wr_ctrl = write_en && (addr_write == 4'd0);
  assign wr_stat = write_en && (addr_write == 4'd1);
  assign wr_addr = write_en && (addr_write == 4'd2);
  assign push    = write_en && (addr_write == 4'd3);

  assign level   = wptr_q - rptr_q;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok = push && !full;
  assign pop     = fb_valid_o && fb_ready_i;
  assign vs_rise = vsync_i && !vsync_q;

  assign enable_o   = ctrl_q[0];
  assign irq_o      = irq_q;
  assign fb_valid_o = ctrl_q[0] && !empty;
  assign fb_addr_o  = addr_q;
  assign fb_data_o  = mem_q[rptr_q[AW-1:0]];
  assign data2axil  = rdata_q;

`ifdef VGA_NATIVE_REGS_FRAME_CNT_EN
  logic [31:0] frame_cnt_q;
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)     frame_cnt_q <= '0;
    else if (vs_rise) frame_cnt_q <= frame_cnt_q + 32'd1;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  // Read mux sees only current register values, so a read never observes a
  // same-cycle write or event.
  always_comb begin
    rd_mux = '0;
    case (addr_read)
      4'd0: rd_mux = {30'd0, ctrl_q};
      4'd1: rd_mux = {16'd0, 8'(level), 4'd0, vpend_q, ovf_q, full, empty};
      4'd2: rd_mux = 32'(addr_q);
      4'd4: rd_mux = frame_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    vpend_d = vpend_q;
    addr_d  = addr_q;
    rdata_d = read_en_sync ? rd_mux : rdata_q;
    if (wr_ctrl) ctrl_d = data2native[1:0];
    if (wr_stat && data2native[2]) ovf_d = 1'b0;
    if (push && full) ovf_d = 1'b1;
    if (wr_stat && data2native[3]) vpend_d = 1'b0;
    if (vs_rise) vpend_d = 1'b1;   // a new edge beats a same-cycle clear
    // CPU write to FB_ADDR beats the pop increment.
    if (wr_addr)
      addr_d = data2native[FB_ADDR_W-1:0];
    else if (pop)
      addr_d = (addr_q == FB_ADDR_W'(FB_SIZE-1)) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ctrl_q  <= '0;
      ovf_q   <= 1'b0;
      vpend_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      vsync_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      vpend_q <= vpend_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      irq_q   <= vpend_d && ctrl_d[1];
      vsync_q <= vsync_i;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is cleared too so fb_data_o reads 0 out of reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= data2native[PIXEL_W-1:0];
    end
  end

  // Only the low bits of the write bus are architecturally meaningful.
  logic unused_wdata;
  assign unused_wdata = ^data2native;

endmodule

// File: tb/tb_vga_native_regs.sv
module tb_vga_native_regs;
  localparam int DEPTH = 8;
  localparam int FBS   = 307200;
`ifdef VGA_NATIVE_REGS_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic [3:0]  addr_write = '0, addr_read = '0;
  logic        write_en = 1'b0, read_en_sync = 1'b0;
  logic [31:0] data2native = '0;
  logic [31:0] data2axil;
  logic        vsync_i = 1'b0, fb_ready_i = 1'b0;
  logic        enable_o, irq_o, fb_valid_o;
  logic [18:0] fb_addr_o;
  logic [11:0] fb_data_o;

  always #5 clk_i = ~clk_i;

  vga_native_regs dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .addr_write(addr_write), .write_en(write_en), .data2native(data2native),
    .addr_read(addr_read), .read_en_sync(read_en_sync), .data2axil(data2axil),
    .vsync_i(vsync_i), .enable_o(enable_o), .irq_o(irq_o),
    .fb_valid_o(fb_valid_o), .fb_ready_i(fb_ready_i),
    .fb_addr_o(fb_addr_o), .fb_data_o(fb_data_o)
  );

  // Behavioural model: a pixel queue plus plain register variables.
  logic [11:0]  q[$];
  logic [1:0]   m_ctrl;
  bit           m_ovf, m_vpend, m_vprev;
  int unsigned  m_addr;
  logic [31:0]  m_fc, m_rd;
  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [3:0] a);
    logic [7:0] lvl;
    lvl = 8'(q.size());
    case (a)
      4'd0: return {30'd0, m_ctrl};
      4'd1: return {16'd0, lvl, 4'd0, m_vpend, m_ovf, q.size() == DEPTH, q.size() == 0};
      4'd2: return m_addr;
      4'd4: return FC_EN ? m_fc : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mreset();
    q.delete();
    m_ctrl = '0; m_ovf = 0; m_vpend = 0; m_vprev = 0;
    m_addr = 0; m_fc = '0; m_rd = '0;
  endtask

  task automatic check_outs();
    chk("rdata",  data2axil, m_rd);
    chk("enable", 32'(enable_o), 32'(m_ctrl[0]));
    chk("irq",    32'(irq_o), 32'(m_vpend && m_ctrl[1]));
    chk("valid",  32'(fb_valid_o), 32'(m_ctrl[0] && q.size() > 0));
    chk("fbaddr", 32'(fb_addr_o), m_addr);
    if (q.size() > 0) chk("fbdata", 32'(fb_data_o), 32'(q[0]));
  endtask

  // One clock with the given strobes; the model advances at the edge.
  task automatic cyc(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                     input bit re, input logic [3:0] ra, input bit vs, input bit rdy);
    logic [31:0] rv;
    bit pop, full, rise;
    write_en = we; addr_write = wa; data2native = wd;
    read_en_sync = re; addr_read = ra; vsync_i = vs; fb_ready_i = rdy;
    @(posedge clk_i);
    rv   = mread(ra);
    pop  = m_ctrl[0] && q.size() > 0 && rdy;
    full = (q.size() == DEPTH);
    rise = vs && !m_vprev;
    if (re) m_rd = rv;
    if (pop) begin
      void'(q.pop_front());
      m_addr = (m_addr + 1) % FBS;
    end
    if (we && wa == 4'd3) begin
      if (full) m_ovf = 1;
      else q.push_back(wd[11:0]);
    end
    if (we && wa == 4'd0) m_ctrl = wd[1:0];
    if (we && wa == 4'd1) begin
      if (wd[2]) m_ovf = 0;
      if (wd[3]) m_vpend = 0;
    end
    if (we && wa == 4'd2) m_addr = wd[18:0];
    if (rise) begin m_vpend = 1; m_fc = m_fc + 1; end
    m_vprev = vs;
    #1;
    write_en = 0; read_en_sync = 0;
    check_outs();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit vs, input bit rdy);
    cyc(1, a, d, 0, 0, vs, rdy);
  endtask
  task automatic rd(input logic [3:0] a, input bit vs, input bit rdy);
    cyc(0, 0, 0, 1, a, vs, rdy);
  endtask

  initial begin
    bit vs;
    logic [3:0] wa;
    logic [31:0] wd;
    mreset();
    // Reset state
    #2;
    chk("rst_valid", 32'(fb_valid_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #2 arst_ni = 1'b1;
    check_outs();
    chk("rst_fbdata", 32'(fb_data_o), 32'd0);
    rd(4'd1, 0, 0);
    chk("rst_status", data2axil, 32'h1);

    // Read STATUS in the same cycle as a push into an empty FIFO
    cyc(1, 4'd3, 32'h5A5, 1, 4'd1, 0, 0);
    chk("rdwr_old", data2axil, 32'h1);
    rd(4'd1, 0, 0);
    chk("rdwr_new", data2axil, 32'h0100);

    // Fill to full plus one more push: overflow
    for (int i = 0; i < 8; i++) wr(4'd3, 32'h100 + i, 0, 0);
    rd(4'd1, 0, 0);
    chk("ovf_status", data2axil, 32'h0806);
    wr(4'd1, 32'h4, 0, 0);
    rd(4'd1, 0, 0);
    chk("ovf_w1c", data2axil, 32'h0802);

    // CTRL write/read
    wr(4'd0, 32'h3, 0, 0);
    rd(4'd0, 0, 0);
    chk("ctrl_rd", data2axil, 32'h3);
    chk("ctrl_en", 32'(enable_o), 32'd1);

    // Drain 4, then reset with 4 queued and ready held high
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("q4_valid", 32'(fb_valid_o), 32'd1);
    arst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(fb_valid_o), 32'd0);
    mreset();
    @(posedge clk_i);
    #2 arst_ni = 1'b1;
    check_outs();
    rd(4'd1, 0, 1);
    chk("arst_status", data2axil, 32'h1);

    // Address wrap at FB_SIZE-1
    wr(4'd2, FBS - 2, 0, 1);
    wr(4'd0, 32'h1, 0, 1);
    wr(4'd3, 32'hABC, 0, 1);
    chk("wrap_a0", 32'(fb_addr_o), FBS - 2);
    chk("wrap_d0", 32'(fb_data_o), 32'hABC);
    wr(4'd3, 32'h123, 0, 1);
    chk("wrap_a1", 32'(fb_addr_o), FBS - 1);
    chk("wrap_d1", 32'(fb_data_o), 32'h123);
    cyc(0, 0, 0, 0, 0, 0, 1);
    rd(4'd2, 0, 1);
    chk("wrap_addr", data2axil, 32'h0);

    // Vsync edges, irq and frame count
    wr(4'd0, 32'h3, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("vs_irq", 32'(irq_o), 32'd1);
    rd(4'd4, 1, 0);
    chk("frame_cnt", data2axil, FC_EN ? 32'd3 : 32'd0);
    wr(4'd1, 32'h8, 0, 0);
    chk("vs_clr_irq", 32'(irq_o), 32'd0);
    wr(4'd1, 32'h8, 1, 0);
    rd(4'd1, 1, 0);
    chk("vs_set_wins", 32'(data2axil[3]), 32'd1);

    // Randomized traffic against the model
    vs = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0: wa = 4'd0; 1: wa = 4'd1; 2: wa = 4'd2; 7: wa = 4'($urandom_range(4, 15));
        default: wa = 4'd3;
      endcase
      wd = $urandom();
      if (wa == 4'd2)
        wd = ($urandom_range(0, 1) == 1) ? FBS - 1 - $urandom_range(0, 3) : $urandom_range(0, FBS - 1);
      if (wa == 4'd0 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) vs = ~vs;
      cyc($urandom_range(0, 2) == 0, wa, wd, $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 15)), vs, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
